// File: rtl/noc_local_sink.sv
// noc_params: shared NoC types (VC count, flit format) used by the local sink.
// noc_local_sink: ejection-side network interface on a router's local output.
//   Buffers incoming flits per VC, reports on/off and allocatable status back
//   to the router, checks packet framing and destination, and delivers whole
//   packets to the local consumer over valid/ready with round-robin VC choice.
// Ports:
//   clk, rst          clock / asynchronous active-low reset
//   data_i, is_valid_i   flit from the router local output
//   is_on_off_o       per-VC on/off (enough free slots left)
//   is_allocatable_o  per-VC idle-and-empty indication
//   flit_o, flit_valid_o, flit_ready_i  consumer handshake (fall-through)
//   err_o             sticky per-VC protocol error
//   pkt_count_o       delivered packet counter (wraps)

package noc_params;
  localparam int unsigned VC_NUM           = 2;
  localparam int unsigned VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned DEST_ADDR_SIZE_X = 2;
  localparam int unsigned DEST_ADDR_SIZE_Y = 2;
  localparam int unsigned PAYLOAD_SIZE     = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
  } head_data_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    head_data_t                head_data;
    logic [PAYLOAD_SIZE-1:0]   data;
  } flit_t;
endpackage

module noc_local_sink
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE   = 8,
  parameter int unsigned MY_X          = 0,
  parameter int unsigned MY_Y          = 0,
  parameter int unsigned ON_OFF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             data_i,
  input  logic              is_valid_i,
  output logic [VC_NUM-1:0] is_on_off_o,
  output logic [VC_NUM-1:0] is_allocatable_o,
  output flit_t             flit_o,
  output logic              flit_valid_o,
  input  logic              flit_ready_i,
  output logic [VC_NUM-1:0] err_o,
  output logic [15:0]       pkt_count_o
);

  localparam int unsigned PTR_W    = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned ON_LIMIT = BUFFER_SIZE - ON_OFF_MARGIN;

  typedef enum logic {
    IDLE      = 1'b0,
    RECEIVING = 1'b1
  } rx_state_t;

  // Read-side state
  logic               locked;      // packet in flight on locked_vc
  logic [VC_SIZE-1:0] locked_vc;
  logic               hold;        // previous cycle presented a flit that was not taken
  logic [VC_SIZE-1:0] hold_vc;
  logic [VC_SIZE-1:0] rr_ptr;
  logic [15:0]        pkt_count;

  logic [VC_SIZE-1:0] sel;
  logic [VC_SIZE-1:0] rr_sel;
  logic               rr_found;
  logic               fire;
  logic [VC_NUM-1:0]  empty;
  flit_t              head_flit [VC_NUM];
  logic               dest_bad;

  assign dest_bad = (data_i.head_data.x_dest != DEST_ADDR_SIZE_X'(MY_X)) ||
                    (data_i.head_data.y_dest != DEST_ADDR_SIZE_Y'(MY_Y));

  // Per-VC buffer, receive FSM and status flags
  for (genvar v = 0; v < int'(VC_NUM); v++) begin : g_vc
    flit_t            mem [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             err_q;
    logic             on_off_q;
    logic             alloc_q;
    logic             wr_en;
    logic             wr_ok;
    logic             rd_en;
    logic             proto_err;

    assign wr_en        = is_valid_i && (data_i.vc_id == VC_SIZE'(v));
    // A full buffer rejects the write even if a read frees a slot this edge.
    assign wr_ok        = wr_en && (count != CNT_W'(BUFFER_SIZE));
    assign rd_en        = fire && (sel == VC_SIZE'(v));
    assign empty[v]     = (count == '0);
    assign head_flit[v] = mem[rd_ptr];
    assign count_nxt    = count + CNT_W'(wr_ok) - CNT_W'(rd_en);

    // Framing / destination checks and next receive state
    always_comb begin
      state_nxt = state;
      proto_err = wr_en && !wr_ok;
      if (wr_ok) begin
        case (data_i.flit_label)
          HEAD: begin
            if (state == RECEIVING || dest_bad) proto_err = 1'b1;
            state_nxt = RECEIVING;
          end
          HEADTAIL: begin
            if (state == RECEIVING || dest_bad) proto_err = 1'b1;
            state_nxt = IDLE;
          end
          BODY: begin
            if (state == IDLE) proto_err = 1'b1;
          end
          TAIL: begin
            if (state == IDLE) proto_err = 1'b1;
            state_nxt = IDLE;
          end
          default: state_nxt = state;
        endcase
      end
    end

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        state    <= IDLE;
        err_q    <= 1'b0;
        on_off_q <= 1'b1;
        alloc_q  <= 1'b1;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        count    <= count_nxt;
        state    <= state_nxt;
        if (proto_err) err_q <= 1'b1;
        on_off_q <= (count_nxt <= CNT_W'(ON_LIMIT));
        alloc_q  <= (state_nxt == IDLE) && (count_nxt == '0);
      end
    end

    assign is_on_off_o[v]      = on_off_q;
    assign is_allocatable_o[v] = alloc_q;
    assign err_o[v]            = err_q;
  end

  // Round-robin search over non-empty VCs, starting after rr_ptr
  always_comb begin
    rr_sel   = rr_ptr;
    rr_found = 1'b0;
    for (int i = 1; i <= int'(VC_NUM); i++) begin
      if (!rr_found && !empty[VC_SIZE'((int'(rr_ptr) + i) % int'(VC_NUM))]) begin
        rr_found = 1'b1;
        rr_sel   = VC_SIZE'((int'(rr_ptr) + i) % int'(VC_NUM));
      end
    end
  end

  // Selection: in-flight packet first, then a stalled presentation, then RR
  always_comb begin
    if (locked)    sel = locked_vc;
    else if (hold) sel = hold_vc;
    else           sel = rr_sel;
    flit_valid_o = !empty[sel];
    flit_o       = flit_valid_o ? head_flit[sel] : '0;
    fire         = flit_valid_o && flit_ready_i;
  end

  // Packet lock, round-robin pointer and delivered-packet counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked    <= 1'b0;
      locked_vc <= '0;
      hold      <= 1'b0;
      hold_vc   <= '0;
      rr_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      hold    <= flit_valid_o && !flit_ready_i;
      hold_vc <= sel;
      if (fire) begin
        case (head_flit[sel].flit_label)
          HEAD: begin
            locked    <= 1'b1;
            locked_vc <= sel;
            rr_ptr    <= sel;
          end
          HEADTAIL: begin
            locked    <= 1'b0;
            rr_ptr    <= sel;
            pkt_count <= pkt_count + 16'd1;
          end
          TAIL: begin
            locked    <= 1'b0;
            pkt_count <= pkt_count + 16'd1;
          end
          default: locked <= locked;
        endcase
      end
    end
  end

  assign pkt_count_o = pkt_count;

endmodule

// File: tb/tb_noc_local_sink.sv
// Directed bench for noc_local_sink: drives flits, keeps a queue of the flits
// the consumer should see in order, and checks status outputs at fixed points.
module tb_noc_local_sink;
  import noc_params::*;

  localparam int unsigned MY_X = 0;
  localparam int unsigned MY_Y = 0;

  logic              clk;
  logic              rst;
  flit_t             data;
  logic              is_valid;
  logic [VC_NUM-1:0] is_on_off;
  logic [VC_NUM-1:0] is_allocatable;
  flit_t             flit_out;
  logic              flit_valid;
  logic              flit_ready;
  logic [VC_NUM-1:0] err;
  logic [15:0]       pkt_count;

  int    checks = 0;
  int    errors = 0;
  flit_t sb [$];

  noc_local_sink #(
    .BUFFER_SIZE  (8),
    .MY_X         (MY_X),
    .MY_Y         (MY_Y),
    .ON_OFF_MARGIN(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_i          (data),
    .is_valid_i      (is_valid),
    .is_on_off_o     (is_on_off),
    .is_allocatable_o(is_allocatable),
    .flit_o          (flit_out),
    .flit_valid_o    (flit_valid),
    .flit_ready_i    (flit_ready),
    .err_o           (err),
    .pkt_count_o     (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input int vc, input int x,
                               input int y, input int d);
    flit_t f;
    f.flit_label       = l;
    f.vc_id            = VC_SIZE'(vc);
    f.head_data.x_dest = DEST_ADDR_SIZE_X'(x);
    f.head_data.y_dest = DEST_ADDR_SIZE_Y'(y);
    f.data             = PAYLOAD_SIZE'(d);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one flit for one edge; optionally record it as expected output
  task automatic send(input flit_t f, input bit expect_out);
    data     = f;
    is_valid = 1'b1;
    if (expect_out) sb.push_back(f);
    step();
    is_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || flit_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_on_off"}, 64'(is_on_off), 64'(2'b11));
    chk({tag, "_alloc"},  64'(is_allocatable), 64'(2'b11));
    chk({tag, "_valid"},  64'(flit_valid), 64'd0);
    chk({tag, "_flit"},   64'(flit_out), 64'd0);
    chk({tag, "_err"},    64'(err), 64'd0);
    chk({tag, "_pkt"},    64'(pkt_count), 64'd0);
  endtask

  // Consumer-side scoreboard: each accepted flit must match the queue head
  always @(negedge clk) begin
    if (rst && flit_valid && flit_ready) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("flit_order", 64'(flit_out), 64'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    flit_label_t l;
    rst        = 1'b0;
    is_valid   = 1'b0;
    flit_ready = 1'b0;
    data       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    step();

    // HEAD then TAIL back to back on vc0 with consumer ready
    flit_ready = 1'b1;
    chk("t1_alloc_pre", 64'(is_allocatable[0]), 64'd1);
    send(mk(HEAD, 0, MY_X, MY_Y, 16'h0011), 1'b1);
    chk("t1_alloc_after_head", 64'(is_allocatable[0]), 64'd0);
    chk("t1_valid_n1", 64'(flit_valid), 64'd1);
    send(mk(TAIL, 0, 0, 0, 16'h0012), 1'b1);
    chk("t1_valid_n2", 64'(flit_valid), 64'd1);
    step();
    chk("t1_valid_done", 64'(flit_valid), 64'd0);
    chk("t1_pkt", 64'(pkt_count), 64'd1);
    chk("t1_alloc_post", 64'(is_allocatable[0]), 64'd1);
    chk("t1_err", 64'(err), 64'd0);

    // Fill vc0 with the consumer stalled, overflow once, then drain
    flit_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      l = (k == 1) ? HEAD : ((k == 8) ? TAIL : BODY);
      send(mk(l, 0, MY_X, MY_Y, 16'h0020 + k), 1'b1);
      chk("t2_on_off", 64'(is_on_off[0]), 64'(k <= 6));
    end
    chk("t2_err_before_ovf", 64'(err[0]), 64'd0);
    send(mk(BODY, 0, 0, 0, 16'h002F), 1'b0);
    chk("t2_err_ovf", 64'(err[0]), 64'd1);
    chk("t2_on_off_full", 64'(is_on_off[0]), 64'd0);
    chk("t2_head_stable", 64'(flit_out), 64'(mk(HEAD, 0, MY_X, MY_Y, 16'h0021)));
    flit_ready = 1'b1;
    drain(40);
    chk("t2_pkt", 64'(pkt_count), 64'd2);
    chk("t2_on_off_after", 64'(is_on_off[0]), 64'd1);

    // Interleaved packets on vc0/vc1: delivered whole, vc0 then vc1
    rst = 1'b0;
    sb.delete();
    step();
    rst = 1'b1;
    step();
    flit_ready = 1'b0;
    send(mk(HEAD, 0, MY_X, MY_Y, 16'h0030), 1'b0);
    chk("t3_first_presented", 64'(flit_out), 64'(mk(HEAD, 0, MY_X, MY_Y, 16'h0030)));
    send(mk(HEAD, 1, MY_X, MY_Y, 16'h0040), 1'b0);
    chk("t3_stable_while_stalled", 64'(flit_out), 64'(mk(HEAD, 0, MY_X, MY_Y, 16'h0030)));
    send(mk(BODY, 0, 0, 0, 16'h0031), 1'b0);
    send(mk(BODY, 1, 0, 0, 16'h0041), 1'b0);
    send(mk(TAIL, 0, 0, 0, 16'h0032), 1'b0);
    send(mk(TAIL, 1, 0, 0, 16'h0042), 1'b0);
    sb.push_back(mk(HEAD, 0, MY_X, MY_Y, 16'h0030));
    sb.push_back(mk(BODY, 0, 0, 0, 16'h0031));
    sb.push_back(mk(TAIL, 0, 0, 0, 16'h0032));
    sb.push_back(mk(HEAD, 1, MY_X, MY_Y, 16'h0040));
    sb.push_back(mk(BODY, 1, 0, 0, 16'h0041));
    sb.push_back(mk(TAIL, 1, 0, 0, 16'h0042));
    chk("t3_alloc_busy", 64'(is_allocatable), 64'(2'b00));
    flit_ready = 1'b1;
    drain(40);
    chk("t3_pkt", 64'(pkt_count), 64'd2);
    chk("t3_err", 64'(err), 64'd0);
    chk("t3_alloc_free", 64'(is_allocatable), 64'(2'b11));

    // Orphan BODY on idle vc1: error on vc1 only, still delivered
    send(mk(BODY, 1, 0, 0, 16'h0050), 1'b1);
    chk("t4_err", 64'(err), 64'(2'b10));
    drain(20);
    chk("t4_pkt", 64'(pkt_count), 64'd2);

    // HEAD addressed to another node on vc0
    send(mk(HEAD, 0, MY_X + 1, MY_Y, 16'h0060), 1'b1);
    chk("t5_err", 64'(err), 64'(2'b11));
    send(mk(TAIL, 0, 0, 0, 16'h0061), 1'b1);
    drain(20);
    chk("t5_pkt", 64'(pkt_count), 64'd3);

    // Asynchronous reset with a partial packet buffered
    flit_ready = 1'b0;
    send(mk(HEAD, 0, MY_X, MY_Y, 16'h0070), 1'b0);
    send(mk(BODY, 0, 0, 0, 16'h0071), 1'b0);
    send(mk(BODY, 0, 0, 0, 16'h0072), 1'b0);
    chk("t6_valid_before", 64'(flit_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("t6_async");
    sb.delete();
    step();
    rst = 1'b1;
    step();
    flit_ready = 1'b1;
    send(mk(HEAD, 1, MY_X, MY_Y, 16'h0080), 1'b1);
    send(mk(TAIL, 1, 0, 0, 16'h0081), 1'b1);
    drain(20);
    chk("t6_pkt", 64'(pkt_count), 64'd1);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_alloc", 64'(is_allocatable), 64'(2'b11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_local_sink.md
Name: noc_local_sink

Overview:
- Ejection-side network interface attached to one router's local output port in the mesh.
- Accepts flits from the router, buffers them per virtual channel and drives the router's local `is_on_off_i` / `is_allocatable_i` inputs.
- Checks packet framing and destination, then presents flits to the local consumer through a valid/ready interface, using round-robin VC arbitration.
- It is the receiving counterpart of flit injection at a node's local input.

Parameters:
- BUFFER_SIZE, 8, flit slots per VC buffer (power of 2, ≥4).
- MY_X, 0, mesh X coordinate of the attached node.
- MY_Y, 0, mesh Y coordinate of the attached node.
- ON_OFF_MARGIN, 2, free slots that must remain for `is_on_off_o[v]` to stay high (covers router round-trip).
- VC_NUM, flit_t and flit_label_t come from noc_params.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  flit_t  flit from the router local output (router `data_o`).
- is_valid_i  in  1  flit on data_i is valid this cycle (router `is_valid_o`).
- is_on_off_o  out  VC_NUM  per-VC credit/on-off to the router (router `is_on_off_i`).
- is_allocatable_o  out  VC_NUM  per-VC "VC free for a new packet" (router `is_allocatable_i`).
- flit_o  out  flit_t  flit presented to the consumer.
- flit_valid_o  out  1  flit_o valid.
- flit_ready_i  in  1  consumer accepts flit_o when valid & ready.
- err_o  out  VC_NUM  sticky per-VC protocol error.
- pkt_count_o  out  16  completed packets delivered to the consumer (wraps at 2^16).

Behaviour:
- Reset (rst=0, async) sets the following:
  - all buffers empty, all VC FSMs IDLE;
  - is_on_off_o=all 1, is_allocatable_o=all 1;
  - flit_valid_o=0, flit_o=0, err_o=0, pkt_count_o=0;
  - round-robin pointer=0.
- Reset asserted mid-packet discards all buffered flits. No partial packet survives.
- Write side: when is_valid_i=1, the flit is written into buffer[data_i.vc_id] at the same edge.
- Full-buffer write: the flit is dropped and err_o[vc] is set. No pointer change.
- Per-VC receive FSM has states IDLE and RECEIVING:
  - IDLE + HEADTAIL → IDLE.
  - IDLE + HEAD → RECEIVING.
  - RECEIVING + BODY → RECEIVING.
  - RECEIVING + TAIL → IDLE.
  - IDLE + BODY/TAIL → set err_o[vc], store flit anyway, stay IDLE.
  - RECEIVING + HEAD/HEADTAIL → set err_o[vc], store flit, state per the new label.
- HEAD/HEADTAIL with head_data.x_dest≠MY_X or y_dest≠MY_Y → set err_o[vc]; the flit is still stored.
- err_o bits clear only on reset.
- is_on_off_o[v] is registered: 1 iff free slots after this edge's update > ON_OFF_MARGIN−1, i.e. occupancy ≤ BUFFER_SIZE−ON_OFF_MARGIN.
- is_allocatable_o[v] is registered: 1 iff the FSM is IDLE and buffer[v] is empty after the update.
  - It drops on the cycle after a HEAD is written.
  - It rises the cycle after the TAIL (or HEADTAIL) is read out by the consumer.
- Read side, output register: flit_o/flit_valid_o are driven from the head of the selected VC buffer (first-word fall-through, no extra register).
- Read side, VC selection:
  - Packet-atomic: once a HEAD is presented from VC v, v stays selected until its TAIL is consumed.
  - If v's buffer runs empty mid-packet, flit_valid_o=0 and no other VC is served.
  - With no packet in flight: round-robin starting at pointer+1 over VCs with a non-empty buffer; the pointer updates to the winner on HEAD/HEADTAIL consumption.
  - An orphan BODY/TAIL at the buffer head with no packet in flight is presented and consumed as a single-flit unit; it does not lock selection.
- Handshake:
  - A flit is consumed when flit_valid_o & flit_ready_i; the read pointer advances at that edge.
  - flit_o is stable while valid & !ready.
- pkt_count_o increments when a TAIL or HEADTAIL is consumed.
- Simultaneous write and read on the same VC: occupancy is unchanged, both pointers advance. A full buffer with a simultaneous read still rejects the write (conservative; counts as overflow error).
- Pointers are log2(BUFFER_SIZE) bits and wrap naturally; the occupancy counter is log2(BUFFER_SIZE)+1 bits.
- Latency: a flit written at edge N is visible on flit_o in cycle N+1 if its VC is selected and the bus is idle.

Test Plan:
- HEAD(vc0,dest=MY) then TAIL(vc0) on consecutive cycles, ready=1:
  - flit_valid_o=1 for 2 cycles from N+1;
  - pkt_count_o=1;
  - is_allocatable_o[0] shows 1→0→1;
  - err_o=0.
- ready=0, stream BUFFER_SIZE flits on vc0 (HEAD, BODY×6, TAIL):
  - is_on_off_o[0]=0 once occupancy reaches 7;
  - 9th write sets err_o[0];
  - then ready=1 drains all 8 in order.
- Interleave HEAD/BODY/TAIL on vc0 and vc1, ready=1:
  - consumer sees each packet contiguous, no interleaving;
  - VCs are served round-robin;
  - pkt_count_o=2.
- BODY on IDLE vc1 → err_o[1]=1 at next edge, err_o[0] stays 0.
- HEAD with x_dest=MY_X+1 → err_o[vc]=1.
- Reset asserted while 3 flits are buffered → all outputs return to reset values at once (async); the next HEAD/TAIL pair is delivered correctly.
